// File: rtl/display_scanner.sv
// Multiplexed-display scan engine: time-slices the segment bus across NUM_DIGITS digits
// with a blanking gap per slot. Define DISPLAY_SCANNER_PWM_EN to build PWM brightness.
module display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 500_000,
    parameter int BLANK_CYCLES = 1_000,
    localparam int SEL_W       = $clog2(NUM_DIGITS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [NUM_DIGITS-1:0] DIGIT_MASK,
    input  logic [3:0]            BRIGHT,
    output logic [SEL_W-1:0]      SEL,
    output logic [NUM_DIGITS-1:0] DIG_EN,
    output logic                  BLANK,
    output logic                  FRAME_TICK
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic                  r_blank;
    logic                  r_frame;

    logic [SEL_W-1:0]      w_lowest;
    logic [SEL_W-1:0]      w_above;
    logic                  w_has_above;
    logic [SEL_W-1:0]      w_next_idx;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  w_frame_nxt;
    logic                  w_lit_nxt;
    logic [NUM_DIGITS-1:0] w_dig_nxt;

    // Lowest set mask bit, and the nearest set bit strictly above the current index.
    always_comb begin
        w_lowest    = '0;
        w_above     = '0;
        w_has_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (DIGIT_MASK[i]) begin
                w_lowest = SEL_W'(i);
            end
            if (DIGIT_MASK[i] && (i > int'(r_sel))) begin
                w_above     = SEL_W'(i);
                w_has_above = 1'b1;
            end
        end
        w_next_idx = w_has_above ? w_above : w_lowest;
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_frame_nxt = 1'b0;
        if (!EN) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_sel_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    w_sel_nxt = '0;
                    if (DIGIT_MASK != '0) begin
                        w_state_nxt = S_GAP;
                        w_sel_nxt   = w_lowest;
                    end
                end
                S_GAP: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        w_state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                        w_cnt_nxt = '0;
                        if (DIGIT_MASK == '0) begin
                            w_state_nxt = S_IDLE;
                            w_sel_nxt   = '0;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_sel_nxt   = w_next_idx;
                            w_frame_nxt = (w_next_idx <= r_sel);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = '0;
                end
            endcase
        end
    end

`ifdef DISPLAY_SCANNER_PWM_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;

    always_comb begin
        w_pwm_nxt = 4'd0;
        if ((w_state_nxt == S_ON) && (r_state == S_ON)) begin
            w_pwm_nxt = r_pwm + 4'd1;
        end
        w_lit_nxt = (w_pwm_nxt <= BRIGHT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    logic w_unused_bright;
    assign w_unused_bright = ^BRIGHT;
    assign w_lit_nxt       = 1'b1;
`endif

    assign w_dig_nxt = ((w_state_nxt == S_ON) && w_lit_nxt) ?
                       (NUM_DIGITS'(1) << w_sel_nxt) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_dig_en <= '0;
            r_blank  <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_dig_en <= w_dig_nxt;
            r_blank  <= (w_dig_nxt == '0);
            r_frame  <= w_frame_nxt;
        end
    end

    assign SEL        = r_sel;
    assign DIG_EN     = r_dig_en;
    assign BLANK      = r_blank;
    assign FRAME_TICK = r_frame;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (NUM_DIGITS=4, DWELL=20, BLANK=4);
// brightness expectations follow DISPLAY_SCANNER_PWM_EN.
module tb_display_scanner;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic [3:0] bright;
    logic [1:0] sel;
    logic [3:0] digEn;
    logic       blank;
    logic       frameTick;

    int total = 0;
    int bad   = 0;

    display_scanner #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(20),
        .BLANK_CYCLES(4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .DIGIT_MASK(mask),
        .BRIGHT    (bright),
        .SEL       (sel),
        .DIG_EN    (digEn),
        .BLANK     (blank),
        .FRAME_TICK(frameTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] m, input logic [3:0] b);
        rst    = r;
        en     = e;
        mask   = m;
        bright = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " sel"},   32'(sel),       32'd0);
        checkOutput({tag, " dig"},   32'(digEn),     32'd0);
        checkOutput({tag, " blank"}, 32'(blank),     32'd1);
        checkOutput({tag, " frame"}, 32'(frameTick), 32'd0);
    endtask

    // Slot cycle k: 0..3 blanked gap, 4..19 lit while (k-4) <= brightness limit.
    task automatic checkCycle(input int expSel, input int k, input logic expFrame, input int br);
        int         litLimit;
        logic [3:0] expDig;
        string      tag;
`ifdef DISPLAY_SCANNER_PWM_EN
        litLimit = br;
`else
        litLimit = 15;
`endif
        expDig = ((k >= 4) && ((k - 4) <= litLimit)) ? 4'(1 << expSel) : 4'd0;
        tag = $sformatf("s%0d k%0d", expSel, k);
        checkOutput({tag, " sel"},   32'(sel),       32'(expSel));
        checkOutput({tag, " dig"},   32'(digEn),     32'(expDig));
        checkOutput({tag, " blank"}, 32'(blank),     32'(expDig == 4'd0));
        checkOutput({tag, " frame"}, 32'(frameTick), 32'((k == 0) ? expFrame : 1'b0));
    endtask

    task automatic checkSlot(input int expSel, input logic expFrame, input int br);
        for (int k = 0; k < 20; k++) begin
            checkCycle(expSel, k, expFrame, br);
            advanceCycle();
        end
    endtask

    initial begin
        // T1: reset then full scan
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'd15);
        repeat (3) advanceCycle();
        checkIdle("reset");
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'd15);
        advanceCycle();
        checkSlot(0, 1'b0, 15);
        checkSlot(1, 1'b0, 15);
        checkSlot(2, 1'b0, 15);
        checkSlot(3, 1'b0, 15);
        checkSlot(0, 1'b1, 15);

        // T2: mask skip, then mid-slot mask change
        mask = 4'b1010;
        checkSlot(1, 1'b0, 15);
        checkSlot(3, 1'b0, 15);
        checkSlot(1, 1'b1, 15);
        mask = 4'b0100;
        checkSlot(3, 1'b0, 15);
        checkSlot(2, 1'b1, 15);
        checkSlot(2, 1'b1, 15);

        // T3: empty mask at slot end, then EN drop during ON
        mask = 4'b0000;
        checkSlot(2, 1'b1, 15);
        for (int i = 0; i < 5; i++) begin
            checkIdle($sformatf("mask0 idle%0d", i));
            advanceCycle();
        end
        mask = 4'b0110;
        advanceCycle();
        checkSlot(1, 1'b0, 15);
        for (int k = 0; k < 7; k++) begin
            checkCycle(2, k, 1'b0, 15);
            advanceCycle();
        end
        en = 1'b0;
        advanceCycle();
        checkIdle("endrop0");
        advanceCycle();
        checkIdle("endrop1");
        en = 1'b1;
        advanceCycle();
        checkSlot(1, 1'b0, 15);
        checkSlot(2, 1'b0, 15);
        checkSlot(1, 1'b1, 15);

        // T4/T5: brightness
        bright = 4'd3;
        checkSlot(2, 1'b0, 3);
        checkSlot(1, 1'b1, 3);
        bright = 4'd0;
        checkSlot(2, 1'b0, 0);
        checkSlot(1, 1'b1, 0);
        bright = 4'd15;

        // T6: reset during ON of a slot
        for (int k = 0; k < 6; k++) begin
            checkCycle(2, k, 1'b0, 15);
            advanceCycle();
        end
        rst = 1'b1;
        advanceCycle();
        checkIdle("midrst0");
        advanceCycle();
        checkIdle("midrst1");
        rst = 1'b0;
        advanceCycle();
        checkSlot(1, 1'b0, 15);
        checkSlot(2, 1'b0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
